// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, captures ROM words into a 2-entry skid buffer,
// and handles redirects with a flush. Optional range checking is compiled in with FETCH_RANGE_CHECK_EN.
module instr_fetch_ctrl #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [ADDR_WIDTH-1:0] ROM_BYTES    = 32'h1000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_instr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [DATA_WIDTH-1:0] dec_instr,
    output logic [ADDR_WIDTH-1:0] dec_pc,
    output logic                  fault,
    output logic [1:0]            dbg_state
);
    // Decode handshake: an entry transfers on any rising edge where dec_valid && dec_ready;
    // dec_valid and the payload hold until that transfer or a redirect flush.
    typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_RUN = 2'd1, ST_FAULT = 2'd2} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fpc_q, fpc_d;
    logic [1:0]              count_q, count_d;
    logic                    head_q, head_d;
    logic                    tail_q, tail_d;
    logic [ADDR_WIDTH-1:0]   buf_pc_q    [2];
    logic [ADDR_WIDTH-1:0]   buf_pc_d    [2];
    logic [DATA_WIDTH-1:0]   buf_instr_q [2];
    logic [DATA_WIDTH-1:0]   buf_instr_d [2];

    logic                    deq;
    logic                    capture;
    logic                    fetch_ok;
    logic                    redir_ok;
    logic [ADDR_WIDTH-1:0]   redir_tgt;

    assign redir_tgt = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign deq       = (count_q != 2'd0) && dec_ready;

`ifdef FETCH_RANGE_CHECK_EN
    // Offset compare keeps the window check correct even if the window touches the top of memory.
    logic [ADDR_WIDTH-1:0] fpc_off, redir_off;
    assign fpc_off   = fpc_q - RESET_VECTOR;
    assign redir_off = redir_tgt - RESET_VECTOR;
    assign fetch_ok  = (fpc_off < ROM_BYTES);
    assign redir_ok  = (redirect_pc[1:0] == 2'b00) && (redir_off < ROM_BYTES);
`else
    assign fetch_ok  = 1'b1;
    assign redir_ok  = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_BOOT;
        else     state_q <= state_d;
    end

    // Next-state logic; a redirect wins over everything except reset
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = redir_ok ? ST_RUN : ST_FAULT;
        end else begin
            case (state_q)
                ST_BOOT:  state_d = ST_RUN;
                ST_RUN:   state_d = fetch_ok ? ST_RUN : ST_FAULT;
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    // Output logic
    always_comb begin
        mem_addr  = fpc_q;
        dec_valid = (count_q != 2'd0);
        dec_pc    = buf_pc_q[head_q];
        dec_instr = buf_instr_q[head_q];
        dbg_state = state_q;
`ifdef FETCH_RANGE_CHECK_EN
        fault     = (state_q == ST_FAULT);
`else
        fault     = 1'b0;
`endif
    end

    // Buffer and fetch PC datapath
    always_comb begin
        capture     = (state_q == ST_RUN) && !redirect_valid && fetch_ok &&
                      ((count_q != 2'd2) || deq);
        fpc_d       = fpc_q;
        count_d     = count_q + {1'b0, capture} - {1'b0, deq};
        head_d      = deq ? ~head_q : head_q;
        tail_d      = capture ? ~tail_q : tail_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        if (capture) begin
            buf_pc_d[tail_q]    = fpc_q;
            buf_instr_d[tail_q] = mem_instr;
            fpc_d               = fpc_q + ADDR_WIDTH'(4);
        end
        if (redirect_valid) begin
            fpc_d   = redir_tgt;
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q          <= RESET_VECTOR;
            count_q        <= 2'd0;
            head_q         <= 1'b0;
            tail_q         <= 1'b0;
            buf_pc_q[0]    <= '0;
            buf_pc_q[1]    <= '0;
            buf_instr_q[0] <= '0;
            buf_instr_q[1] <= '0;
        end else begin
            fpc_q          <= fpc_d;
            count_q        <= count_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            buf_pc_q[0]    <= buf_pc_d[0];
            buf_pc_q[1]    <= buf_pc_d[1];
            buf_instr_q[0] <= buf_instr_d[0];
            buf_instr_q[1] <= buf_instr_d[1];
        end
    end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl; the ROM model returns word index (addr - boot vector) / 4.
module tb_instr_fetch_ctrl;
    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        fault;
    logic [1:0]  dbg_state;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign mem_instr = (mem_addr - RV) >> 2;

    instr_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_instr      (mem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .fault          (fault),
        .dbg_state      (dbg_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, dec_valid}, 32'd1);
        chk({tag, "_pc"}, dec_pc, pc);
        chk({tag, "_instr"}, dec_instr, (pc - RV) >> 2);
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_valid", {31'd0, dec_valid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_addr", mem_addr, RV);
        chk("rst_pc", dec_pc, 32'd0);
        chk("rst_instr", dec_instr, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);

        // Boot with decode always ready: one instruction per cycle after two edges
        rst = 1'b0;
        dec_ready = 1'b1;
        step();
        chk("boot_e0_valid", {31'd0, dec_valid}, 32'd0);
        chk("boot_e0_state", {30'd0, dbg_state}, 32'd1);
        step();
        chk_head("boot_e1", RV);
        step();
        chk_head("boot_e2", RV + 4);
        step();
        chk_head("boot_e3", RV + 8);

        // Reboot with decode stalled: buffer fills and the fetch address holds
        rst = 1'b1;
        dec_ready = 1'b0;
        step();
        chk("reboot_valid", {31'd0, dec_valid}, 32'd0);
        chk("reboot_addr", mem_addr, RV);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("stall_addr", mem_addr, RV + 8);
        chk_head("stall_head", RV);
        dec_ready = 1'b1;
        step();
        chk_head("drain_0", RV + 4);
        step();
        chk_head("drain_1", RV + 8);
        step();
        chk_head("drain_2", RV + 12);

        // Redirect while full: head transfers, other entry dropped
        dec_ready = 1'b0;
        step();
        step();
        chk("full_addr_hold", mem_addr, RV + 32'h14);
        chk_head("full_head", RV + 12);
        dec_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = RV + 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("redir_valid_n", {31'd0, dec_valid}, 32'd0);
        chk("redir_addr_n", mem_addr, RV + 32'h100);
        step();
        chk_head("redir_n1", RV + 32'h100);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc = RV + 32'h102;
        step();
        redirect_valid = 1'b0;
        chk("misal_valid", {31'd0, dec_valid}, 32'd0);
        chk("misal_addr", mem_addr, RV + 32'h100);
`ifdef FETCH_RANGE_CHECK_EN
        chk("misal_fault", {31'd0, fault}, 32'd1);
        step();
        chk("misal_hold_valid", {31'd0, dec_valid}, 32'd0);
        chk("misal_hold_fault", {31'd0, fault}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = RV;
        step();
        redirect_valid = 1'b0;
        chk("recover_fault", {31'd0, fault}, 32'd0);
        chk("recover_addr", mem_addr, RV);
        step();
        chk_head("recover_head", RV);

        // Sequential fetch off the end of the ROM window
        redirect_valid = 1'b1;
        redirect_pc = RV + 32'hFF8;
        step();
        redirect_valid = 1'b0;
        step();
        chk_head("end_ff8", RV + 32'hFF8);
        step();
        chk_head("end_ffc", RV + 32'hFFC);
        chk("end_ffc_fault", {31'd0, fault}, 32'd0);
        step();
        chk("end_valid", {31'd0, dec_valid}, 32'd0);
        chk("end_fault", {31'd0, fault}, 32'd1);
`else
        chk("misal_fault", {31'd0, fault}, 32'd0);
        step();
        chk_head("misal_head", RV + 32'h100);
        step();
        chk_head("misal_next", RV + 32'h104);
`endif

        // Reset mid-stream with two entries buffered
        dec_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = RV;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        chk_head("pre_rst_head", RV);
        chk("pre_rst_addr", mem_addr, RV + 8);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", {31'd0, dec_valid}, 32'd0);
        chk("mid_rst_addr", mem_addr, RV);
        chk("mid_rst_state", {30'd0, dbg_state}, 32'd0);
        chk("mid_rst_fault", {31'd0, fault}, 32'd0);
        rst = 1'b0;
        dec_ready = 1'b1;
        step();
        chk("rb_e0_valid", {31'd0, dec_valid}, 32'd0);
        step();
        chk_head("rb_e1", RV);
        step();
        chk_head("rb_e2", RV + 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
